sram_like_arbiter: RTL and testbench
====================================

Name: sram_like_arbiter

Overview:
Shares the single SRAM-like memory port between the fetch side (read-only) and the load/store side. Data requests have fixed priority, with an anti-starvation escape for fetch. In-flight request owners are tracked in order, so each mem_data_ok and its mem_rdata reach the correct requester, including the writeback stage's data_data_ok/data_rdata. Request and response paths are combinational pass-throughs (zero added latency); only the arbitration state is registered.

Parameters:
MAX_OUTSTANDING, 4, owner-FIFO depth = max accepted-but-unanswered requests; power of 2, >=2
STARVE_LIMIT, 3, consecutive data grants made while inst_req is pending before fetch is forced; >=1

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
inst_req  in  1  fetch request, held until inst_addr_ok
inst_addr  in  32  fetch address (word read, size fixed 2'd2)
inst_addr_ok  out  1  fetch request accepted
inst_data_ok  out  1  fetch response valid
inst_rdata  out  32  fetch read data
data_req  in  1  load/store request, held until data_addr_ok
data_wr  in  1  1=store
data_size  in  2  0=byte, 1=half, 2=word
data_addr  in  32  load/store address
data_wdata  in  32  store data
data_addr_ok  out  1  load/store request accepted
data_data_ok  out  1  load/store response valid (store ack or load data)
data_rdata  out  32  load data
mem_req  out  1  shared-port request
mem_wr  out  1  forwarded wr (0 for fetch)
mem_size  out  2  forwarded size (2'd2 for fetch)
mem_addr  out  32  forwarded address
mem_wdata  out  32  forwarded wdata (0 for fetch)
mem_addr_ok  in  1  slave accepted request
mem_data_ok  in  1  slave response; responses return in acceptance order
mem_rdata  in  32  slave read data

Behaviour:
- Registered state: lock (FREE / LOCK_I / LOCK_D), owner FIFO (1 bit per entry: 1=data), wr/rd pointers, count, starve counter. Async reset: lock=FREE, count=0, pointers=0, starve=0.
- Combinational outputs are therefore 0 at reset unless inst_req or data_req is high: inst_data_ok=data_data_ok=0 (FIFO empty).
- full = (count == MAX_OUTSTANDING).
- mem_req = !full && (inst_req || data_req).
- Selection in FREE:
  - force_i = inst_req && starve == STARVE_LIMIT.
  - sel = data if data_req && !force_i, else inst.
- Selection in LOCK_I / LOCK_D: sel is fixed to the locked side regardless of the other request.
- mem_* outputs are muxed from the selected side.
- Handshake: hs = mem_req && mem_addr_ok. inst_addr_ok = hs && sel==inst; data_addr_ok = hs && sel==data.
- Lock transitions:
  - FREE -> LOCK_x when mem_req && !mem_addr_ok (the presented request must not change).
  - LOCK_x -> FREE on hs.
  - A lock cannot coexist with full, because no push occurs while locked.
- Push: on hs, write sel to FIFO[wr_ptr]; wr_ptr wraps modulo MAX_OUTSTANDING.
- Pop: on mem_data_ok && count != 0, read FIFO[rd_ptr], then rd_ptr++ (wrap).
  - Owner bit 1: data_data_ok = 1. Owner bit 0: inst_data_ok = 1.
  - inst_rdata = data_rdata = mem_rdata unconditionally.
- count: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
- When full, no push occurs, even if a pop happens in the same cycle.
- mem_data_ok with count==0 is a protocol violation: ignored, no *_data_ok, no state change.
- Starve counter:
  - +1 (saturating at STARVE_LIMIT) on a data hs while inst_req=1.
  - Cleared on an inst hs or whenever inst_req=0.
- Reset mid-operation clears all tags. Responses still in flight are then dropped by the empty-FIFO rule.

Test Plan:
1. Single load: data_req=1, addr=0x100, size=2, mem_addr_ok=1 cycle 0, mem_data_ok=1 cycle 2 with rdata=0xDEADBEEF -> data_addr_ok@0, data_data_ok@2 with data_rdata=0xDEADBEEF, inst_data_ok=0.
2. Contention with lock: inst_req and data_req both high, mem_addr_ok=0 for 2 cycles, then 1 -> mem_addr=data_addr throughout; a new force condition arising during the lock does not switch mem_addr; data_addr_ok only.
3. Starvation: both requests continuously high, mem_addr_ok=1 every cycle, STARVE_LIMIT=3 -> grant order D,D,D,I,D,D,D,I; owner FIFO order matches.
4. Full: 4 fetches accepted with no mem_data_ok -> mem_req=0 on the 5th; one mem_data_ok -> inst_data_ok=1 and mem_req returns to 1 the next cycle.
5. Interleaved order: accept I,D,I, then 3 mem_data_ok with rdata 1,2,3 -> inst_data_ok, data_data_ok, inst_data_ok respectively, with matching rdata.
6. Reset and spurious response: resetn low with 2 requests outstanding, release, then mem_data_ok=1 -> no *_data_ok; count stays 0.

Source files
------------

// File: rtl/sram_like_arbiter.sv
// sram_like_arbiter
//   Shares one SRAM-like memory port between instruction fetch (read-only) and
//   load/store. Data wins by default; fetch is forced after STARVE_LIMIT data
//   grants while it waits. A request that stalls on mem_addr_ok locks the
//   selection until it is accepted. An owner FIFO records which side each
//   accepted request belongs to, so in-order responses are steered back to
//   the correct requester. Request and response paths are purely combinational.
//
// Ports
//   clk, resetn                   clock, asynchronous active-low reset
//   inst_req/addr -> addr_ok      fetch request channel (word reads)
//   inst_data_ok, inst_rdata      fetch response
//   data_req/wr/size/addr/wdata   load/store request channel
//   data_addr_ok                  load/store request accepted
//   data_data_ok, data_rdata      load/store response
//   mem_req/wr/size/addr/wdata    shared memory request
//   mem_addr_ok                   memory accepted the request
//   mem_data_ok, mem_rdata        memory response, in acceptance order
module sram_like_arbiter #(
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned STARVE_LIMIT    = 3
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned PtrW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned CntW = PtrW + 1;
    localparam int unsigned StW  = $clog2(STARVE_LIMIT + 1);

    localparam logic [1:0] StFree  = 2'd0;
    localparam logic [1:0] StLockI = 2'd1;
    localparam logic [1:0] StLockD = 2'd2;

    logic [1:0]                 lock_q, lock_d;
    logic [MAX_OUTSTANDING-1:0] fifo_q, fifo_d;
    logic [PtrW-1:0]            wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]            rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]            count_q, count_d;
    logic [StW-1:0]             starve_q, starve_d;

    logic full, force_i, sel_data, hs, push, pop, owner;

    always_comb begin
        full    = (count_q == CntW'(MAX_OUTSTANDING));
        mem_req = !full && (inst_req || data_req);
        force_i = inst_req && (starve_q == StW'(STARVE_LIMIT));

        // A stalled request must stay on the port unchanged until accepted.
        unique case (lock_q)
            StLockI: sel_data = 1'b0;
            StLockD: sel_data = 1'b1;
            default: sel_data = data_req && !force_i;
        endcase

        mem_wr    = sel_data ? data_wr    : 1'b0;
        mem_size  = sel_data ? data_size  : 2'd2;
        mem_addr  = sel_data ? data_addr  : inst_addr;
        mem_wdata = sel_data ? data_wdata : 32'd0;

        hs           = mem_req && mem_addr_ok;
        inst_addr_ok = hs && !sel_data;
        data_addr_ok = hs && sel_data;

        // Responses with nothing outstanding are ignored.
        push  = hs;
        pop   = mem_data_ok && (count_q != '0);
        owner = fifo_q[rd_ptr_q];

        inst_data_ok = pop && !owner;
        data_data_ok = pop && owner;
        inst_rdata   = mem_rdata;
        data_rdata   = mem_rdata;
    end

    always_comb begin
        lock_d = lock_q;
        if (lock_q == StFree) begin
            if (mem_req && !mem_addr_ok) begin
                lock_d = sel_data ? StLockD : StLockI;
            end
        end else if (hs) begin
            lock_d = StFree;
        end

        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            fifo_d[wr_ptr_q] = sel_data;
            wr_ptr_d         = wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end

        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CntW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CntW'(1);
        end

        // Counts data grants that overtook a waiting fetch.
        starve_d = starve_q;
        if (!inst_req || inst_addr_ok) begin
            starve_d = '0;
        end else if (data_addr_ok && (starve_q != StW'(STARVE_LIMIT))) begin
            starve_d = starve_q + StW'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lock_q   <= StFree;
            fifo_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            starve_q <= '0;
        end else begin
            lock_q   <= lock_d;
            fifo_q   <= fifo_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            starve_q <= starve_d;
        end
    end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed bench for sram_like_arbiter. A queue-based reference model is
// checked against the DUT every cycle; directed steps add literal checks.
module tb_sram_like_arbiter;

    localparam int MAXO = 4;
    localparam int LIM  = 3;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        inst_req = 1'b0;
    logic [31:0] inst_addr = 32'h0;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req = 1'b0;
    logic        data_wr = 1'b0;
    logic [1:0]  data_size = 2'd2;
    logic [31:0] data_addr = 32'h0;
    logic [31:0] data_wdata = 32'h0;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        mem_req, mem_wr;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_addr_ok = 1'b0;
    logic        mem_data_ok = 1'b0;
    logic [31:0] mem_rdata = 32'h0;

    int n_tests = 0;
    int n_fail  = 0;

    sram_like_arbiter #(.MAX_OUTSTANDING(MAXO), .STARVE_LIMIT(LIM)) dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: owners of outstanding requests (1 = data), starve count,
    // side a stalled request is pinned to (0 none, 1 inst, 2 data).
    bit owners[$];
    int starve_m = 0;
    int lock_m   = 0;
    bit e_full, e_req, e_sd, e_hs, e_pop, e_own;

    always @(negedge clk) begin
        if (!resetn) begin
            owners.delete();
            starve_m = 0;
            lock_m   = 0;
        end else begin
            e_full = (owners.size() == MAXO);
            e_req  = !e_full && (inst_req || data_req);
            if (lock_m == 1)      e_sd = 1'b0;
            else if (lock_m == 2) e_sd = 1'b1;
            else                  e_sd = data_req && !(inst_req && starve_m == LIM);
            e_hs  = e_req && mem_addr_ok;
            e_pop = mem_data_ok && (owners.size() != 0);
            e_own = e_pop ? owners[0] : 1'b0;

            chk("m_mem_req", mem_req, e_req);
            chk("m_inst_addr_ok", inst_addr_ok, e_hs && !e_sd);
            chk("m_data_addr_ok", data_addr_ok, e_hs && e_sd);
            chk("m_inst_data_ok", inst_data_ok, e_pop && !e_own);
            chk("m_data_data_ok", data_data_ok, e_pop && e_own);
            chk("m_inst_rdata", inst_rdata, mem_rdata);
            chk("m_data_rdata", data_rdata, mem_rdata);
            if (e_req) begin
                chk("m_mem_addr", mem_addr, e_sd ? data_addr : inst_addr);
                chk("m_mem_wr", mem_wr, e_sd ? data_wr : 1'b0);
                chk("m_mem_size", mem_size, e_sd ? data_size : 2'd2);
                chk("m_mem_wdata", mem_wdata, e_sd ? data_wdata : 32'd0);
            end

            if (e_pop) void'(owners.pop_front());
            if (e_hs) owners.push_back(e_sd);
            if (lock_m == 0 && e_req && !mem_addr_ok) lock_m = e_sd ? 2 : 1;
            else if (e_hs) lock_m = 0;
            if (!inst_req || (e_hs && !e_sd)) starve_m = 0;
            else if (e_hs && e_sd && starve_m < LIM) starve_m++;
        end
    end

    // Drive one cycle's control inputs just after the edge, then settle.
    task automatic cyc(input logic ir, input logic dr, input logic maok, input logic mdok,
                       input logic [31:0] rd);
        @(posedge clk);
        #1;
        inst_req    = ir;
        data_req    = dr;
        mem_addr_ok = maok;
        mem_data_ok = mdok;
        mem_rdata   = rd;
        #1;
    endtask

    logic [7:0] pat;

    initial begin
        inst_addr = 32'h200;
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        #1;
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_inst_data_ok", inst_data_ok, 1'b0);
        chk("rst_data_data_ok", data_data_ok, 1'b0);

        // 1: single load
        data_addr = 32'h100; data_size = 2'd2; data_wr = 1'b0;
        cyc(0, 1, 1, 0, 32'h0);
        chk("t1_data_addr_ok", data_addr_ok, 1'b1);
        chk("t1_mem_addr", mem_addr, 32'h100);
        cyc(0, 0, 0, 0, 32'h0);
        chk("t1_idle_mem_req", mem_req, 1'b0);
        cyc(0, 0, 0, 1, 32'hDEADBEEF);
        chk("t1_data_data_ok", data_data_ok, 1'b1);
        chk("t1_data_rdata", data_rdata, 32'hDEADBEEF);
        chk("t1_inst_data_ok", inst_data_ok, 1'b0);

        // 2: contention with a stall, selection pinned to data
        data_addr = 32'h300;
        cyc(1, 1, 0, 0, 32'h0);
        chk("t2_mem_addr0", mem_addr, 32'h300);
        cyc(1, 1, 0, 0, 32'h0);
        chk("t2_mem_addr1", mem_addr, 32'h300);
        chk("t2_no_ack", data_addr_ok | inst_addr_ok, 1'b0);
        cyc(1, 1, 1, 0, 32'h0);
        chk("t2_data_addr_ok", data_addr_ok, 1'b1);
        chk("t2_inst_addr_ok", inst_addr_ok, 1'b0);
        cyc(0, 0, 0, 1, 32'h77);
        chk("t2_data_data_ok", data_data_ok, 1'b1);

        // 3: starvation escape, grants D,D,D,I,D,D,D,I; responses follow grants
        pat = 8'b0111_0111;
        for (int k = 0; k < 8; k++) begin
            cyc(1, 1, 1, k != 0, 32'(k));
            chk("t3_grant", data_addr_ok, pat[k]);
            chk("t3_grant_i", inst_addr_ok, !pat[k]);
            if (k != 0) chk("t3_owner", data_data_ok, pat[k-1]);
        end
        cyc(0, 0, 0, 1, 32'h8);
        chk("t3_last_owner", inst_data_ok, 1'b1);

        // 4: full
        for (int k = 0; k < 4; k++) begin
            cyc(1, 0, 1, 0, 32'h0);
            chk("t4_accept", inst_addr_ok, 1'b1);
        end
        cyc(1, 0, 1, 1, 32'h44);
        chk("t4_full_mem_req", mem_req, 1'b0);
        chk("t4_full_no_ack", inst_addr_ok, 1'b0);
        chk("t4_pop", inst_data_ok, 1'b1);
        cyc(1, 0, 1, 0, 32'h0);
        chk("t4_mem_req_back", mem_req, 1'b1);
        chk("t4_accept_after", inst_addr_ok, 1'b1);
        for (int k = 0; k < 4; k++) begin
            cyc(0, 0, 0, 1, 32'(k));
            chk("t4_drain", inst_data_ok, 1'b1);
        end

        // 5: interleaved I, D(store byte), I then in-order responses
        data_wr = 1'b1; data_size = 2'd0; data_wdata = 32'hA5; data_addr = 32'h404;
        cyc(1, 0, 1, 0, 32'h0);
        chk("t5_i0", inst_addr_ok, 1'b1);
        cyc(0, 1, 1, 0, 32'h0);
        chk("t5_d", data_addr_ok, 1'b1);
        chk("t5_mem_wr", mem_wr, 1'b1);
        chk("t5_mem_size", mem_size, 2'd0);
        chk("t5_mem_wdata", mem_wdata, 32'hA5);
        cyc(1, 0, 1, 0, 32'h0);
        chk("t5_i1", inst_addr_ok, 1'b1);
        chk("t5_fetch_wr", mem_wr, 1'b0);
        cyc(0, 0, 0, 1, 32'h1);
        chk("t5_r1", inst_data_ok, 1'b1);
        chk("t5_r1_data", inst_rdata, 32'h1);
        cyc(0, 0, 0, 1, 32'h2);
        chk("t5_r2", data_data_ok, 1'b1);
        chk("t5_r2_data", data_rdata, 32'h2);
        cyc(0, 0, 0, 1, 32'h3);
        chk("t5_r3", inst_data_ok, 1'b1);
        chk("t5_r3_data", inst_rdata, 32'h3);

        // 6: reset with two outstanding, then a stale response
        cyc(1, 0, 1, 0, 32'h0);
        cyc(1, 0, 1, 0, 32'h0);
        cyc(0, 0, 0, 0, 32'h0);
        resetn = 1'b0;
        @(posedge clk);
        #1 resetn = 1'b1;
        cyc(0, 0, 0, 1, 32'h55);
        chk("t6_no_inst_ok", inst_data_ok, 1'b0);
        chk("t6_no_data_ok", data_data_ok, 1'b0);
        for (int k = 0; k < 4; k++) begin
            cyc(1, 0, 1, 0, 32'h0);
            chk("t6_accept", inst_addr_ok, 1'b1);
        end
        cyc(1, 0, 1, 0, 32'h0);
        chk("t6_full_after_4", mem_req, 1'b0);
        cyc(0, 0, 0, 0, 32'h0);
        repeat (2) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
